// File: rtl/draw_cmd_pkg.sv
// Shared definitions for the draw command sequencer: header field layout,
// opcode values and FSM state encoding.
package draw_cmd_pkg;

  // Header word layout: [31:28] opcode, [23:16] payload count, [15:0] base address
  localparam int unsigned OPC_MSB     = 31;
  localparam int unsigned OPC_LSB     = 28;
  localparam int unsigned CNT_MSB     = 23;
  localparam int unsigned CNT_LSB     = 16;
  localparam int unsigned ADR_MSB     = 15;
  localparam int unsigned ADR_LSB     = 0;

  localparam int unsigned OPC_W       = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned CNT_W       = CNT_MSB - CNT_LSB + 1;
  localparam int unsigned ADR_FIELD_W = ADR_MSB - ADR_LSB + 1;

  localparam logic [OPC_W-1:0] OP_NOP      = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_REGWRITE = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_DRAW     = OPC_W'(2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_WAIT,
    ST_DECODE,
    ST_PAY_REQ,
    ST_PAY_WAIT,
    ST_DRAW_KICK,
    ST_DRAW_WAIT
  } state_t;

endpackage

// File: rtl/draw_cmd_hdr_decode.sv
// Combinational header decoder for the draw command sequencer.
// Ports:
//   hdr          - latched 32-bit header word
//   opcode_valid - opcode is one of NOP / REGWRITE / DRAW
//   is_nop, is_regwrite, is_draw - one-hot opcode flags
//   count        - payload word count N
//   base         - first register address (low ADDR_W bits of the base field)
module draw_cmd_hdr_decode
  import draw_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic [31:0]       hdr,
  output logic              opcode_valid,
  output logic              is_nop,
  output logic              is_regwrite,
  output logic              is_draw,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] base
);

  logic [OPC_W-1:0]       opcode;
  logic [ADR_FIELD_W-1:0] adr_field;
  logic                   unused_hdr;

  assign opcode       = hdr[OPC_MSB:OPC_LSB];
  assign count        = hdr[CNT_MSB:CNT_LSB];
  assign adr_field    = hdr[ADR_MSB:ADR_LSB];
  assign base         = adr_field[ADDR_W-1:0];

  assign is_nop       = (opcode == OP_NOP);
  assign is_regwrite  = (opcode == OP_REGWRITE);
  assign is_draw      = (opcode == OP_DRAW);
  assign opcode_valid = is_nop | is_regwrite | is_draw;

  // Reserved bits and base bits above ADDR_W carry no meaning
  assign unused_hdr   = ^{hdr[OPC_LSB-1:CNT_MSB+1], adr_field};

endmodule

// File: rtl/draw_cmd_sequencer.sv
// Draw command sequencer: pops words from the command buffer, decodes
// headers and issues register writes / draw kicks to the draw engine.
// Optional feature: define DRAW_CMD_TIMEOUT_EN to add a DRAW_WAIT watchdog
// (TIMEOUT_CYC cycles) that sets ERR[1] and returns to IDLE.
// Ports:
//   CLK, RST (sync, active-high), INIT (sync soft clear)
//   EMPTY, DATAVALID, INDATA, BUF_RD       - command buffer read side
//   REG_WE, REG_ADDR, REG_WDATA            - draw register write port
//   DRAW_START, DRAW_DONE                  - draw kick handshake
//   BUSY, ERR[1:0], CMD_COUNT[15:0]        - status
module draw_cmd_sequencer
  import draw_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INIT,
  input  logic              EMPTY,
  input  logic              DATAVALID,
  input  logic [31:0]       INDATA,
  output logic              BUF_RD,
  output logic              REG_WE,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [31:0]       REG_WDATA,
  output logic              DRAW_START,
  input  logic              DRAW_DONE,
  output logic              BUSY,
  output logic [1:0]        ERR,
  output logic [15:0]       CMD_COUNT
);

  state_t            state;
  logic [31:0]       hdr_q;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] addr;

  logic              dec_valid;
  logic              dec_nop;
  logic              dec_regwrite;
  logic              dec_draw;
  logic [CNT_W-1:0]  dec_count;
  logic [ADDR_W-1:0] dec_base;

  logic              unused_dec;

  draw_cmd_hdr_decode #(.ADDR_W(ADDR_W)) u_hdr_decode (
    .hdr          (hdr_q),
    .opcode_valid (dec_valid),
    .is_nop       (dec_nop),
    .is_regwrite  (dec_regwrite),
    .is_draw      (dec_draw),
    .count        (dec_count),
    .base         (dec_base)
  );

  // NOP is the fall-through case of DECODE, so its flag is not consulted
  assign unused_dec = dec_nop;

`ifdef DRAW_CMD_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd_cnt;
  logic        wd_expired;
  assign wd_expired = (wd_cnt == WD_LIMIT);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^16'(TIMEOUT_CYC);
`endif

  // Main sequencer FSM; all outputs registered
  always_ff @(posedge CLK) begin
    if (RST || INIT) begin
      state      <= ST_IDLE;
      BUF_RD     <= 1'b0;
      REG_WE     <= 1'b0;
      REG_ADDR   <= '0;
      REG_WDATA  <= '0;
      DRAW_START <= 1'b0;
      BUSY       <= 1'b0;
      ERR        <= 2'b00;
      CMD_COUNT  <= '0;
      hdr_q      <= '0;
      remaining  <= '0;
      addr       <= '0;
`ifdef DRAW_CMD_TIMEOUT_EN
      wd_cnt     <= '0;
`endif
    end else begin
      BUF_RD     <= 1'b0;
      REG_WE     <= 1'b0;
      DRAW_START <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!EMPTY) begin
            BUF_RD <= 1'b1;
            BUSY   <= 1'b1;
            state  <= ST_HDR_WAIT;
          end
        end

        ST_HDR_WAIT: begin
          if (DATAVALID) begin
            hdr_q <= INDATA;
            state <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          if (!dec_valid) begin
            ERR[0] <= 1'b1;
            BUSY   <= 1'b0;
            state  <= ST_IDLE;
          end else if (dec_draw) begin
            state <= ST_DRAW_KICK;
          end else if (dec_regwrite && (dec_count != '0)) begin
            remaining <= dec_count;
            addr      <= dec_base;
            // Issue the first payload read straight away to save a cycle
            if (!EMPTY) begin
              BUF_RD <= 1'b1;
              state  <= ST_PAY_WAIT;
            end else begin
              state  <= ST_PAY_REQ;
            end
          end else begin
            // NOP, or REGWRITE with an empty payload
            CMD_COUNT <= CMD_COUNT + 16'(1);
            BUSY      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_PAY_REQ: begin
          if (!EMPTY) begin
            BUF_RD <= 1'b1;
            state  <= ST_PAY_WAIT;
          end
        end

        ST_PAY_WAIT: begin
          if (DATAVALID) begin
            REG_WE    <= 1'b1;
            REG_ADDR  <= addr;
            REG_WDATA <= INDATA;
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              CMD_COUNT <= CMD_COUNT + 16'(1);
              BUSY      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              state <= ST_PAY_REQ;
            end
          end
        end

        ST_DRAW_KICK: begin
          DRAW_START <= 1'b1;
          state      <= ST_DRAW_WAIT;
`ifdef DRAW_CMD_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
        end

        ST_DRAW_WAIT: begin
          // Completion wins over a coincident watchdog expiry
          if (DRAW_DONE) begin
            CMD_COUNT <= CMD_COUNT + 16'(1);
            BUSY      <= 1'b0;
            state     <= ST_IDLE;
          end
`ifdef DRAW_CMD_TIMEOUT_EN
          else if (wd_expired) begin
            ERR[1] <= 1'b1;
            BUSY   <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'(1);
          end
`endif
        end

        default: begin
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Directed self-checking bench for draw_cmd_sequencer with a small
// 1-cycle-latency FIFO model on the command buffer side.
module tb_draw_cmd_sequencer;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic              empty;
  logic              datavalid;
  logic [31:0]       indata;
  logic              buf_rd;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_wdata;
  logic              draw_start;
  logic              draw_done;
  logic              busy;
  logic [1:0]        err;
  logic [15:0]       cmd_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    int                c;
  } wr_t;

  logic [31:0] fifo_q[$];
  wr_t         wr_log[$];
  int          rd_log[$];
  int          ds_cnt = 0;
  logic        rd_pend = 1'b0;
  logic [31:0] pend_data = '0;

  draw_cmd_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(100)) dut (
    .CLK        (clk),
    .RST        (rst),
    .INIT       (init),
    .EMPTY      (empty),
    .DATAVALID  (datavalid),
    .INDATA     (indata),
    .BUF_RD     (buf_rd),
    .REG_WE     (reg_we),
    .REG_ADDR   (reg_addr),
    .REG_WDATA  (reg_wdata),
    .DRAW_START (draw_start),
    .DRAW_DONE  (draw_done),
    .BUSY       (busy),
    .ERR        (err),
    .CMD_COUNT  (cmd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Command buffer model: data valid one cycle after the pop
  initial begin
    empty     = 1'b1;
    datavalid = 1'b0;
    indata    = '0;
    forever begin
      @(negedge clk);
      datavalid = rd_pend;
      if (rd_pend) indata = pend_data;
      rd_pend = (buf_rd === 1'b1);
      if (rd_pend) begin
        chk("no_underflow", 32'(fifo_q.size() != 0), 32'd1);
        if (fifo_q.size() != 0) pend_data = fifo_q.pop_front();
      end
      empty = (fifo_q.size() == 0);
    end
  end

  // Output monitor
  initial forever begin
    @(negedge clk);
    if (reg_we === 1'b1) begin
      wr_log.push_back('{a: reg_addr, d: reg_wdata, c: cyc});
      chk("we_start_excl", 32'(draw_start), 32'd0);
    end
    if (buf_rd === 1'b1) rd_log.push_back(cyc);
    if (draw_start === 1'b1) ds_cnt++;
  end

  function automatic bit sys_idle();
    return (busy == 1'b0) && (fifo_q.size() == 0) && !rd_pend && !datavalid;
  endfunction

  task automatic wait_idle(input int bound);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!sys_idle() && i < bound);
    chk("idle_reached", 32'(sys_idle()), 32'd1);
  endtask

  task automatic wait_draw_start(input int bound);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (draw_start !== 1'b1 && i < bound);
    chk("draw_start_seen", 32'(draw_start), 32'd1);
  endtask

  task automatic wait_writes(input int n, input int bound);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (wr_log.size() < n && i < bound);
    chk("writes_seen", 32'(wr_log.size()), 32'(n));
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    ds_cnt = 0;
  endtask

  initial begin
    rst       = 1'b1;
    init      = 1'b0;
    draw_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_buf_rd", 32'(buf_rd), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_draw_start", 32'(draw_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cmd_count", 32'(cmd_count), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", reg_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // REGWRITE N=3 at 0x10
    clear_logs();
    fifo_q.push_back(32'h10030010);
    fifo_q.push_back(32'h0000000A);
    fifo_q.push_back(32'h0000000B);
    fifo_q.push_back(32'h0000000C);
    wait_idle(100);
    chk("rw_nwr", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3 && rd_log.size() > 0) begin
      chk("rw_a0", 32'(wr_log[0].a), 32'h10);
      chk("rw_d0", wr_log[0].d, 32'hA);
      chk("rw_a1", 32'(wr_log[1].a), 32'h11);
      chk("rw_d1", wr_log[1].d, 32'hB);
      chk("rw_a2", 32'(wr_log[2].a), 32'h12);
      chk("rw_d2", wr_log[2].d, 32'hC);
      chk("rw_latency", 32'(wr_log[0].c - rd_log[0]), 32'd5);
      chk("rw_spacing", 32'(wr_log[1].c - wr_log[0].c), 32'd3);
    end
    chk("rw_nrd", 32'(rd_log.size()), 32'd4);
    chk("rw_count", 32'(cmd_count), 32'd1);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_err", 32'(err), 32'd0);
    chk("rw_hold_addr", 32'(reg_addr), 32'h12);
    chk("rw_hold_data", reg_wdata, 32'hC);

    // DRAW with DRAW_DONE 20 cycles after DRAW_START
    clear_logs();
    fifo_q.push_back(32'h20000000);
    wait_draw_start(20);
    repeat (20) @(negedge clk);
    chk("draw_busy_wait", 32'(busy), 32'd1);
    chk("draw_count_wait", 32'(cmd_count), 32'd1);
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    chk("draw_busy_done", 32'(busy), 32'd0);
    chk("draw_count", 32'(cmd_count), 32'd2);
    chk("draw_nstart", 32'(ds_cnt), 32'd1);
    chk("draw_nrd", 32'(rd_log.size()), 32'd1);
    // Stray DRAW_DONE while idle is ignored
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    @(negedge clk);
    chk("draw_stray_done", 32'(cmd_count), 32'd2);

    // REGWRITE N=2 at 0xFF with a payload stall; address wraps to 0x00
    clear_logs();
    fifo_q.push_back(32'h100200FF);
    fifo_q.push_back(32'h11111111);
    wait_writes(1, 30);
    repeat (3) @(negedge clk);
    chk("wrap_stall_busy", 32'(busy), 32'd1);
    chk("wrap_stall_nrd", 32'(rd_log.size()), 32'd2);
    fifo_q.push_back(32'h22222222);
    wait_idle(50);
    chk("wrap_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("wrap_a0", 32'(wr_log[0].a), 32'hFF);
      chk("wrap_d0", wr_log[0].d, 32'h11111111);
      chk("wrap_a1", 32'(wr_log[1].a), 32'h00);
      chk("wrap_d1", wr_log[1].d, 32'h22222222);
    end
    chk("wrap_count", 32'(cmd_count), 32'd3);
    chk("wrap_hold_addr", 32'(reg_addr), 32'h00);

    // Bad opcode followed by a NOP, then INIT clears status
    clear_logs();
    fifo_q.push_back(32'h70000000);
    fifo_q.push_back(32'h00000000);
    wait_idle(50);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_count", 32'(cmd_count), 32'd4);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("init_err", 32'(err), 32'd0);
    chk("init_count", 32'(cmd_count), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);

    // REGWRITE with N=0 behaves as NOP
    clear_logs();
    fifo_q.push_back(32'h10000055);
    wait_idle(50);
    chk("n0_count", 32'(cmd_count), 32'd1);
    chk("n0_nwr", 32'(wr_log.size()), 32'd0);

    // INIT during PAY_WAIT of an N=4 command after two writes
    clear_logs();
    fifo_q.push_back(32'h10040020);
    fifo_q.push_back(32'hD1D1D1D1);
    fifo_q.push_back(32'hD2D2D2D2);
    fifo_q.push_back(32'h00000000);
    fifo_q.push_back(32'h00000000);
    wait_writes(2, 50);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_reg_we", 32'(reg_we), 32'd0);
    chk("abort_count", 32'(cmd_count), 32'd0);
    wait_idle(50);
    chk("abort_nwr", 32'(wr_log.size()), 32'd2);
    chk("abort_tail_nop", 32'(cmd_count), 32'd1);
    fifo_q.push_back(32'h10010030);
    fifo_q.push_back(32'h5A5A5A5A);
    wait_idle(50);
    chk("post_nwr", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chk("post_a", 32'(wr_log[2].a), 32'h30);
      chk("post_d", wr_log[2].d, 32'h5A5A5A5A);
    end
    chk("post_count", 32'(cmd_count), 32'd2);
    chk("post_err", 32'(err), 32'd0);

`ifdef DRAW_CMD_TIMEOUT_EN
    // DRAW with no completion: watchdog fires at cycle 100 of DRAW_WAIT
    clear_logs();
    fifo_q.push_back(32'h20000000);
    wait_draw_start(20);
    repeat (99) @(negedge clk);
    chk("to_err_before", 32'(err), 32'd0);
    chk("to_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_err", 32'(err), 32'd2);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_count", 32'(cmd_count), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_cmd_sequencer.md
Name: draw_cmd_sequencer

Overview:
- Drains the draw command buffer (32-bit FIFO with 1-cycle read latency and a valid flag) one word at a time.
- Parses each header word and sequences the resulting actions: register-file writes to the draw engine, DRAW kick/wait handshakes, and NOPs.
- Sits between the command buffer's read side and the draw engine's register and control interface.
- Sole owner of BUF_RD.

Parameters:
- ADDR_W, 8, width of the draw register address; header base field is [ADDR_W-1:0], ADDR_W ≤ 16.
- TIMEOUT_CYC, 65535, DRAW_WAIT watchdog limit in cycles; used only with the optional feature.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- INIT  in  1  synchronous soft clear (abort and flush state).
- EMPTY  in  1  command buffer empty.
- DATAVALID  in  1  buffer read data valid, one cycle after BUF_RD.
- INDATA  in  32  buffer read data.
- BUF_RD  out  1  buffer pop, single-cycle pulse.
- REG_WE  out  1  draw register write strobe.
- REG_ADDR  out  ADDR_W  draw register address.
- REG_WDATA  out  32  draw register write data.
- DRAW_START  out  1  draw kick, one-cycle pulse.
- DRAW_DONE  in  1  draw engine completion pulse.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  2  sticky errors: [0] bad opcode, [1] draw timeout.
- CMD_COUNT  out  16  completed commands, wraps 0xFFFF→0.

Behaviour:
- Header format: [31:28] opcode, [23:16] payload count N, [15:0] base address (low ADDR_W bits used).
- Opcodes: 0x0 NOP, 0x1 REGWRITE, 0x2 DRAW. All other opcodes are errors.
- Reset (RST=1): state IDLE; every output 0; ERR, CMD_COUNT and internal counters cleared.
- INIT=1: same effect as reset on state, outputs, ERR and CMD_COUNT. Takes priority over all state transitions.
- States: IDLE, HDR_WAIT, DECODE, PAY_REQ, PAY_WAIT, DRAW_KICK, DRAW_WAIT.
- IDLE: if EMPTY=0, pulse BUF_RD and go to HDR_WAIT.
- HDR_WAIT: on DATAVALID=1, latch header and go to DECODE. Otherwise hold; no further BUF_RD.
- DECODE:
  - NOP: CMD_COUNT+1, go to IDLE.
  - REGWRITE with N=0: treated as NOP.
  - REGWRITE with N>0: load remaining=N, addr=base, go to PAY_REQ.
  - DRAW: go to DRAW_KICK.
  - Other opcode: set ERR[0], CMD_COUNT unchanged, go to IDLE. Payload words of a bad command are not skipped; they are decoded as headers.
- PAY_REQ: if EMPTY=0, pulse BUF_RD and go to PAY_WAIT. If EMPTY=1, stall indefinitely with BUSY held.
- PAY_WAIT: on DATAVALID, capture INDATA.
  - Next cycle: REG_WE=1, REG_ADDR=addr, REG_WDATA=word.
  - addr increments modulo 2^ADDR_W (wrap is silent); remaining decrements.
  - If remaining becomes 0: CMD_COUNT+1, go to IDLE. Otherwise go to PAY_REQ.
- Payload throughput: at most one REG_WE per 2 cycles.
- Only one read is ever outstanding. BUF_RD is never asserted while EMPTY=1.
- Latency: header BUF_RD at t0 → DATAVALID t1 → DECODE t2 → first payload BUF_RD t3 → DATAVALID t4 → REG_WE t5.
- DRAW_KICK: DRAW_START=1 for one cycle, then DRAW_WAIT.
- DRAW_WAIT: on DRAW_DONE=1, CMD_COUNT+1, go to IDLE. A DRAW_DONE outside DRAW_WAIT is ignored.
- REG_WE and DRAW_START are never high together.
- REG_ADDR and REG_WDATA hold their last values when REG_WE=0.

Optional Feature:
- Macro: DRAW_CMD_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counter clears on entry to DRAW_WAIT and counts each cycle in it.
  - Reaching TIMEOUT_CYC sets ERR[1] and forces IDLE; CMD_COUNT does not increment.
  - A DRAW_DONE on the same cycle as the timeout wins: normal completion, no error.
- Undefined: no counter is implemented, ERR[1] is tied 0, and DRAW_WAIT waits forever.

Decomposition:
- Package draw_cmd_pkg holds:
  - opcode constants OP_NOP, OP_REGWRITE, OP_DRAW;
  - the state enum;
  - header field bit positions and widths (OPC_MSB/LSB, CNT_MSB/LSB, ADR_MSB/LSB).
- One sub-module, draw_cmd_hdr_decode: a combinational header→{opcode_valid, is_nop, is_regwrite, is_draw, count, base} decoder.
- The FSM, counters and watchdog stay in the top.

Test Plan:
- Push 0x10030010, 0xA, 0xB, 0xC → REG_WE at addrs 0x10, 0x11, 0x12 with data 0xA, 0xB, 0xC; first REG_WE 5 cycles after the header BUF_RD; CMD_COUNT=1; BUSY low afterward.
- Push 0x20000000; DRAW_DONE 20 cycles after DRAW_START → exactly one DRAW_START pulse; CMD_COUNT=1; no BUF_RD during DRAW_WAIT.
- Push 0x100200FF, then the 2nd payload word 3 cycles later (FIFO empty in between) → writes to 0xFF then 0x00 (wrap); no BUF_RD while EMPTY=1.
- Push 0x70000000 then 0x00000000 → ERR=01; CMD_COUNT=1 (NOP only); INIT pulse → ERR=00, CMD_COUNT=0.
- INIT asserted while in PAY_WAIT of an N=4 command after 2 writes → IDLE next cycle, no further REG_WE; new header processed normally afterward.
- With DRAW_CMD_TIMEOUT_EN and TIMEOUT_CYC=100, DRAW with no DRAW_DONE → ERR[1]=1 at cycle 100 of DRAW_WAIT; IDLE; CMD_COUNT unchanged.
